rv_test_exit_monitor: RTL and testbench

- Synthesizable, multi-hart successor to the bench-level pass/fail check. It snoops each hart's register-file write port and retire strobes, and shadows a0 (x10) and a7 (x17).
- Detects the riscv-tests exit convention: a7 == 0x5d, exit code a0>>1, pass when a0 == 0.
- Provides per-hart cycle/instret counters, a drain window and a global watchdog.
- Sits beside the core(s) in the top level. Drives status pins for the bench, FPGA LEDs or a GPO.

---
 rtl/rv_test_exit_monitor_if.sv | 41 ++++
 rtl/rv_test_exit_monitor.sv | 257 +++++++++++++++++++++++++
 tb/tb_rv_test_exit_monitor.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_test_exit_monitor_if.sv
// ---------------------------------------------------------------------------
// rv_test_exit_monitor_if
//   Snoop bus between one or more RISC-V cores and the exit monitor. It
//   carries each hart's register-file write port plus its retire strobes.
//
//   Signals (hart h occupies the slices noted):
//     rf_we         [NumHarts]     register-file write enable
//     rf_waddr      [5*NumHarts]   write address, hart h at [5h+:5]
//     rf_wdata      [32*NumHarts]  write data, hart h at [32h+:32]
//     instr_retire  [NumHarts]     one pulse per retired instruction
//     ecall_retire  [NumHarts]     pulse when an ecall retires
//
//   Modports:
//     master  - the core side, which drives the bus
//     slave   - the monitor side, which only observes it
// ---------------------------------------------------------------------------
interface rv_test_exit_monitor_if #(
    parameter int NumHarts = 1
);
    logic [NumHarts-1:0]    rf_we;
    logic [5*NumHarts-1:0]  rf_waddr;
    logic [32*NumHarts-1:0] rf_wdata;
    logic [NumHarts-1:0]    instr_retire;
    logic [NumHarts-1:0]    ecall_retire;

    modport master (
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output instr_retire,
        output ecall_retire
    );

    modport slave (
        input rf_we,
        input rf_waddr,
        input rf_wdata,
        input instr_retire,
        input ecall_retire
    );
endinterface

// File: rtl/rv_test_exit_monitor.sv
// ---------------------------------------------------------------------------
// rv_test_exit_monitor
//   Watches one or more harts for the riscv-tests exit convention. The
//   convention is a7 == ExitMagic, with a0 == 0 meaning pass and a0 >> 1
//   being the exit code. The monitor keeps shadow copies of a0 (x10) and
//   a7 (x17) per hart by snooping register-file writes. Each hart runs a
//   RUN -> DRAIN -> DONE sequence, where the drain window lets in-flight
//   stores land before completion is reported. A global watchdog ends the
//   run if the harts never finish.
//
//   Ports:
//     clk_i          system clock
//     rst_i          synchronous reset, active-high, overrides everything
//     en_i           enable; while low nothing advances
//     snoop          register-file write / retire snoop bus (slave modport)
//     hart_done_o    per-hart DONE flag
//     hart_pass_o    per-hart captured (a0 == 0), valid with hart_done_o
//     exit_code_o    per-hart captured a0[31:1], hart h at [31h+:31]
//     cycle_cnt_o    per-hart enabled cycles spent in RUN or DRAIN
//     instret_o      per-hart retired instructions while in RUN
//     done_o         all harts DONE, or the watchdog fired (sticky)
//     pass_o         done_o with no timeout and every hart passing (sticky)
//     timeout_o      watchdog fired (sticky)
// ---------------------------------------------------------------------------
module rv_test_exit_monitor #(
    parameter int          NumHarts      = 1,
    parameter logic [31:0] ExitMagic     = 32'h0000_005d,
    parameter bit          RequireEcall  = 1'b0,
    parameter int          DrainCycles   = 4,
    parameter int          TimeoutCycles = 1_000_000,
    parameter int          CntWidth      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    rv_test_exit_monitor_if.slave        snoop,
    output logic [NumHarts-1:0]          hart_done_o,
    output logic [NumHarts-1:0]          hart_pass_o,
    output logic [31*NumHarts-1:0]       exit_code_o,
    output logic [CntWidth*NumHarts-1:0] cycle_cnt_o,
    output logic [CntWidth*NumHarts-1:0] instret_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         timeout_o
);

    // Per-hart FSM encoding
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Drain counter only needs to reach DrainCycles-1
    localparam int             DcW       = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam bit             DrainEn   = (DrainCycles > 32'sd0);
    localparam logic [DcW-1:0] DrainLast = DrainEn ? DcW'(DrainCycles - 32'sd1) : {DcW{1'b0}};
    localparam logic [DcW-1:0] DcOne     = DcW'(32'd1);

    // Watchdog counter only needs to reach TimeoutCycles-1; the limit is
    // recognised on the edge that would have pushed it to TimeoutCycles.
    localparam int             WdW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit             WdEn   = (TimeoutCycles > 32'sd0);
    localparam logic [WdW-1:0] WdLast = WdEn ? WdW'(TimeoutCycles - 32'sd1) : {WdW{1'b0}};
    localparam logic [WdW-1:0] WdOne  = WdW'(32'd1);

    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(32'd1);
    localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};

    // Per-hart state
    logic [1:0]          state_r [NumHarts];
    logic [1:0]          state_s [NumHarts];
    logic [31:0]         a0_r    [NumHarts];
    logic [31:0]         a0_s    [NumHarts];
    logic [31:0]         a7_r    [NumHarts];
    logic [31:0]         a7_s    [NumHarts];
    logic [DcW-1:0]      drain_r [NumHarts];
    logic [DcW-1:0]      drain_s [NumHarts];
    logic [CntWidth-1:0] cyc_r   [NumHarts];
    logic [CntWidth-1:0] cyc_s   [NumHarts];
    logic [CntWidth-1:0] ins_r   [NumHarts];
    logic [CntWidth-1:0] ins_s   [NumHarts];
    logic [30:0]         code_r  [NumHarts];
    logic [30:0]         code_s  [NumHarts];
    logic [NumHarts-1:0] hpass_r;
    logic [NumHarts-1:0] hpass_s;
    logic [NumHarts-1:0] hdone_r;
    logic [NumHarts-1:0] hdone_s;
    logic [NumHarts-1:0] detect_s;

    // Global state
    logic [WdW-1:0] wd_r;
    logic [WdW-1:0] wd_s;
    logic           wd_hit_s;
    logic           all_done_s;
    logic           advance_s;
    logic           done_r;
    logic           done_s;
    logic           pass_r;
    logic           pass_s;
    logic           timeout_r;
    logic           timeout_s;

    // Next-state logic: shadows, per-hart FSMs, counters and watchdog
    always_comb begin
        // Once the watchdog has fired the harts are frozen where they stand
        advance_s = en_i & ~timeout_r;

        for (int h = 0; h < NumHarts; h++) begin
            a0_s[h]     = a0_r[h];
            a7_s[h]     = a7_r[h];
            state_s[h]  = state_r[h];
            drain_s[h]  = drain_r[h];
            cyc_s[h]    = cyc_r[h];
            ins_s[h]    = ins_r[h];
            code_s[h]   = code_r[h];
            hpass_s[h]  = hpass_r[h];
            detect_s[h] = 1'b0;

            // Shadow update. Address 0 and every other register fall to default.
            if (en_i && snoop.rf_we[h]) begin
                case (snoop.rf_waddr[5*h +: 5])
                    5'd10:   a0_s[h] = snoop.rf_wdata[32*h +: 32];
                    5'd17:   a7_s[h] = snoop.rf_wdata[32*h +: 32];
                    default: a0_s[h] = a0_r[h];
                endcase
            end else begin
                a0_s[h] = a0_r[h];
            end

            // Detection always looks at the registered (pre-update) shadow, so a
            // same-cycle write to a0 or a7 cannot influence this cycle's decision.
            if (RequireEcall) begin
                detect_s[h] = snoop.ecall_retire[h] & (a7_r[h] == ExitMagic);
            end else begin
                detect_s[h] = (a7_r[h] == ExitMagic);
            end

            if (advance_s) begin
                // Saturating cycle counter over RUN and DRAIN
                if (((state_r[h] == ST_RUN) || (state_r[h] == ST_DRAIN)) && (cyc_r[h] != CntMax)) begin
                    cyc_s[h] = cyc_r[h] + CntOne;
                end else begin
                    cyc_s[h] = cyc_r[h];
                end

                // Saturating retire counter, RUN only
                if ((state_r[h] == ST_RUN) && snoop.instr_retire[h] && (ins_r[h] != CntMax)) begin
                    ins_s[h] = ins_r[h] + CntOne;
                end else begin
                    ins_s[h] = ins_r[h];
                end

                case (state_r[h])
                    ST_RUN: begin
                        if (detect_s[h]) begin
                            code_s[h]  = a0_r[h][31:1];
                            hpass_s[h] = (a0_r[h] == 32'd0);
                            drain_s[h] = {DcW{1'b0}};
                            state_s[h] = DrainEn ? ST_DRAIN : ST_DONE;
                        end else begin
                            state_s[h] = ST_RUN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_r[h] == DrainLast) begin
                            state_s[h] = ST_DONE;
                        end else begin
                            drain_s[h] = drain_r[h] + DcOne;
                        end
                    end
                    ST_DONE: begin
                        state_s[h] = ST_DONE;
                    end
                    default: begin
                        state_s[h] = ST_RUN;
                    end
                endcase
            end else begin
                state_s[h] = state_r[h];
            end

            hdone_s[h] = (state_s[h] == ST_DONE);
        end

        all_done_s = &hdone_s;

        // Watchdog counts enabled cycles until the run is reported done
        wd_hit_s = WdEn && en_i && !done_r && (wd_r == WdLast);
        if (WdEn && en_i && !done_r && !wd_hit_s) begin
            wd_s = wd_r + WdOne;
        end else begin
            wd_s = wd_r;
        end

        // Harts finishing on the limit edge take precedence over the timeout
        timeout_s = timeout_r | (wd_hit_s & ~all_done_s);

        if (done_r) begin
            done_s = 1'b1;
            pass_s = pass_r;
        end else begin
            done_s = all_done_s | wd_hit_s;
            pass_s = all_done_s & (&hpass_s);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int h = 0; h < NumHarts; h++) begin
                state_r[h] <= ST_RUN;
                a0_r[h]    <= 32'd0;
                a7_r[h]    <= 32'd0;
                drain_r[h] <= {DcW{1'b0}};
                cyc_r[h]   <= CntZero;
                ins_r[h]   <= CntZero;
                code_r[h]  <= 31'd0;
            end
            hpass_r   <= {NumHarts{1'b0}};
            hdone_r   <= {NumHarts{1'b0}};
            wd_r      <= {WdW{1'b0}};
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            for (int h = 0; h < NumHarts; h++) begin
                state_r[h] <= state_s[h];
                a0_r[h]    <= a0_s[h];
                a7_r[h]    <= a7_s[h];
                drain_r[h] <= drain_s[h];
                cyc_r[h]   <= cyc_s[h];
                ins_r[h]   <= ins_s[h];
                code_r[h]  <= code_s[h];
            end
            hpass_r   <= hpass_s;
            hdone_r   <= hdone_s;
            wd_r      <= wd_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            timeout_r <= timeout_s;
        end
    end

    // Pack per-hart registers onto the flat output buses
    for (genvar g = 0; g < NumHarts; g++) begin : g_out
        assign exit_code_o[31*g +: 31]             = code_r[g];
        assign cycle_cnt_o[CntWidth*g +: CntWidth] = cyc_r[g];
        assign instret_o[CntWidth*g +: CntWidth]   = ins_r[g];
    end

    assign hart_done_o = hdone_r;
    assign hart_pass_o = hpass_r;
    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_rv_test_exit_monitor.sv
// ---------------------------------------------------------------------------
// tb_rv_test_exit_monitor
//   Directed bench for rv_test_exit_monitor. Four instances share the clock,
//   reset and enable:
//     u0  single hart, a7-match exit, 4-cycle drain
//     u1  single hart, ecall-qualified exit, 4-cycle drain
//     u2  two harts, a7-match exit, no drain
//     u3  single hart, 200-cycle watchdog, 4-bit counters
// ---------------------------------------------------------------------------
module tb_rv_test_exit_monitor;

    logic clk;
    logic rst;
    logic en;

    int total;
    int bad;

    rv_test_exit_monitor_if #(.NumHarts(1)) bus0 ();
    rv_test_exit_monitor_if #(.NumHarts(1)) bus1 ();
    rv_test_exit_monitor_if #(.NumHarts(2)) bus2 ();
    rv_test_exit_monitor_if #(.NumHarts(1)) bus3 ();

    logic [0:0]  d0_hdone, d0_hpass;
    logic [30:0] d0_code;
    logic [31:0] d0_cyc, d0_ins;
    logic        d0_done, d0_pass, d0_to;

    logic [0:0]  d1_hdone, d1_hpass;
    logic [30:0] d1_code;
    logic [31:0] d1_cyc, d1_ins;
    logic        d1_done, d1_pass, d1_to;

    logic [1:0]  d2_hdone, d2_hpass;
    logic [61:0] d2_code;
    logic [63:0] d2_cyc, d2_ins;
    logic        d2_done, d2_pass, d2_to;

    logic [0:0]  d3_hdone, d3_hpass;
    logic [30:0] d3_code;
    logic [3:0]  d3_cyc, d3_ins;
    logic        d3_done, d3_pass, d3_to;

    rv_test_exit_monitor #(.NumHarts(1), .RequireEcall(1'b0), .DrainCycles(4)) u0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .snoop(bus0.slave),
        .hart_done_o(d0_hdone), .hart_pass_o(d0_hpass), .exit_code_o(d0_code),
        .cycle_cnt_o(d0_cyc), .instret_o(d0_ins),
        .done_o(d0_done), .pass_o(d0_pass), .timeout_o(d0_to)
    );

    rv_test_exit_monitor #(.NumHarts(1), .RequireEcall(1'b1), .DrainCycles(4)) u1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .snoop(bus1.slave),
        .hart_done_o(d1_hdone), .hart_pass_o(d1_hpass), .exit_code_o(d1_code),
        .cycle_cnt_o(d1_cyc), .instret_o(d1_ins),
        .done_o(d1_done), .pass_o(d1_pass), .timeout_o(d1_to)
    );

    rv_test_exit_monitor #(.NumHarts(2), .RequireEcall(1'b0), .DrainCycles(0)) u2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .snoop(bus2.slave),
        .hart_done_o(d2_hdone), .hart_pass_o(d2_hpass), .exit_code_o(d2_code),
        .cycle_cnt_o(d2_cyc), .instret_o(d2_ins),
        .done_o(d2_done), .pass_o(d2_pass), .timeout_o(d2_to)
    );

    rv_test_exit_monitor #(.NumHarts(1), .DrainCycles(4), .TimeoutCycles(200), .CntWidth(4)) u3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .snoop(bus3.slave),
        .hart_done_o(d3_hdone), .hart_pass_o(d3_hpass), .exit_code_o(d3_code),
        .cycle_cnt_o(d3_cyc), .instret_o(d3_ins),
        .done_o(d3_done), .pass_o(d3_pass), .timeout_o(d3_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus0.rf_we = 1'b0; bus0.rf_waddr = 5'd0;  bus0.rf_wdata = 32'd0;
        bus0.instr_retire = 1'b0; bus0.ecall_retire = 1'b0;
        bus1.rf_we = 1'b0; bus1.rf_waddr = 5'd0;  bus1.rf_wdata = 32'd0;
        bus1.instr_retire = 1'b0; bus1.ecall_retire = 1'b0;
        bus2.rf_we = 2'b00; bus2.rf_waddr = 10'd0; bus2.rf_wdata = 64'd0;
        bus2.instr_retire = 2'b00; bus2.ecall_retire = 2'b00;
        bus3.rf_we = 1'b0; bus3.rf_waddr = 5'd0;  bus3.rf_wdata = 32'd0;
        bus3.instr_retire = 1'b0; bus3.ecall_retire = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        clear_inputs();
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        bus0.rf_we = 1'b1; bus0.rf_waddr = a; bus0.rf_wdata = d;
        tick(1);
        bus0.rf_we = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic ec);
        bus1.rf_we = 1'b1; bus1.rf_waddr = a; bus1.rf_wdata = d; bus1.ecall_retire = ec;
        tick(1);
        bus1.rf_we = 1'b0; bus1.ecall_retire = 1'b0;
    endtask

    task automatic wr2(input int h, input logic [4:0] a, input logic [31:0] d);
        bus2.rf_we = 2'b00;
        bus2.rf_we[h] = 1'b1;
        bus2.rf_waddr[5*h +: 5] = a;
        bus2.rf_wdata[32*h +: 32] = d;
        tick(1);
        bus2.rf_we = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({d0_done, d0_pass, d0_to, d0_hdone, d0_hpass} !== 5'b0) begin
            $display("FAIL reset_u0_flags got=%b want=00000", {d0_done, d0_pass, d0_to, d0_hdone, d0_hpass}); bad++; end
        total++; if ({d0_cyc, d0_ins, d0_code} !== 95'd0) begin
            $display("FAIL reset_u0_counters cyc=%0d ins=%0d code=%0d want=0", d0_cyc, d0_ins, d0_code); bad++; end
        total++; if ({d2_done, d2_pass, d2_to, d2_hdone, d2_hpass} !== 7'b0) begin
            $display("FAIL reset_u2_flags got=%b want=0", {d2_done, d2_pass, d2_to, d2_hdone, d2_hpass}); bad++; end
        total++; if ({d3_done, d3_to, d3_cyc, d3_ins} !== 10'd0) begin
            $display("FAIL reset_u3 got=%b want=0", {d3_done, d3_to, d3_cyc, d3_ins}); bad++; end
    endtask

    task automatic test_pass();
        do_reset();
        wr0(5'd10, 32'd0);
        wr0(5'd17, 32'h5d);
        tick(4);
        total++; if (d0_done !== 1'b0) begin
            $display("FAIL pass_early_done got=%b want=0", d0_done); bad++; end
        tick(1);
        total++; if ({d0_hdone, d0_done, d0_pass, d0_to} !== 4'b1110) begin
            $display("FAIL pass_flags got=%b want=1110", {d0_hdone, d0_done, d0_pass, d0_to}); bad++; end
        total++; if (d0_code !== 31'd0) begin
            $display("FAIL pass_code got=%0d want=0", d0_code); bad++; end
        total++; if (d0_cyc !== 32'd7) begin
            $display("FAIL pass_cycle_cnt got=%0d want=7", d0_cyc); bad++; end
        // DONE is terminal: a later a7 change must not disturb anything
        wr0(5'd17, 32'd0);
        tick(3);
        total++; if ({d0_done, d0_pass, d0_cyc} !== {2'b11, 32'd7}) begin
            $display("FAIL pass_terminal done=%b pass=%b cyc=%0d want 1 1 7", d0_done, d0_pass, d0_cyc); bad++; end
    endtask

    task automatic test_fail_code();
        do_reset();
        bus0.instr_retire = 1'b1;
        tick(3);
        en = 1'b0;
        tick(5);
        total++; if ({d0_ins, d0_cyc} !== {32'd3, 32'd3}) begin
            $display("FAIL en_low_hold ins=%0d cyc=%0d want 3 3", d0_ins, d0_cyc); bad++; end
        en = 1'b1;
        bus0.instr_retire = 1'b0;
        wr0(5'd10, 32'd7);
        wr0(5'd17, 32'h5d);
        tick(1);
        bus0.instr_retire = 1'b1;
        tick(4);
        total++; if ({d0_done, d0_pass, d0_hpass} !== 3'b100) begin
            $display("FAIL fail_flags got=%b want=100", {d0_done, d0_pass, d0_hpass}); bad++; end
        total++; if (d0_code !== 31'd3) begin
            $display("FAIL fail_code got=%0d want=3", d0_code); bad++; end
        total++; if (d0_ins !== 32'd3) begin
            $display("FAIL fail_instret got=%0d want=3", d0_ins); bad++; end
        total++; if (d0_cyc !== 32'd10) begin
            $display("FAIL fail_cycle_cnt got=%0d want=10", d0_cyc); bad++; end
        bus0.instr_retire = 1'b0;
    endtask

    task automatic test_ecall();
        do_reset();
        // a7 written in the same cycle as the ecall: shadow was still 0
        wr1(5'd17, 32'h5d, 1'b1);
        tick(1000);
        total++; if ({d1_done, d1_hdone} !== 2'b00) begin
            $display("FAIL ecall_no_trigger got=%b want=00", {d1_done, d1_hdone}); bad++; end
        bus1.ecall_retire = 1'b1;
        tick(1);
        bus1.ecall_retire = 1'b0;
        tick(3);
        total++; if (d1_done !== 1'b0) begin
            $display("FAIL ecall_early_done got=%b want=0", d1_done); bad++; end
        tick(1);
        total++; if ({d1_hdone, d1_done, d1_pass, d1_to} !== 4'b1110) begin
            $display("FAIL ecall_done got=%b want=1110", {d1_hdone, d1_done, d1_pass, d1_to}); bad++; end
    endtask

    task automatic test_two_harts();
        do_reset();
        wr2(0, 5'd10, 32'd0);
        wr2(0, 5'd17, 32'h5d);
        tick(1);
        total++; if ({d2_hdone, d2_done} !== 3'b010) begin
            $display("FAIL two_h0_done got=%b want=010", {d2_hdone, d2_done}); bad++; end
        wr2(1, 5'd10, 32'd2);
        wr2(1, 5'd17, 32'h5d);
        total++; if ({d2_hdone, d2_done} !== 3'b010) begin
            $display("FAIL two_h1_early got=%b want=010", {d2_hdone, d2_done}); bad++; end
        tick(1);
        total++; if ({d2_hdone, d2_done, d2_pass, d2_hpass} !== 6'b111001) begin
            $display("FAIL two_flags got=%b want=111001", {d2_hdone, d2_done, d2_pass, d2_hpass}); bad++; end
        total++; if (d2_code !== {31'd1, 31'd0}) begin
            $display("FAIL two_codes got=%h want=%h", d2_code, {31'd1, 31'd0}); bad++; end
    endtask

    task automatic test_timeout();
        do_reset();
        bus3.instr_retire = 1'b1;
        tick(199);
        total++; if ({d3_to, d3_done} !== 2'b00) begin
            $display("FAIL timeout_early got=%b want=00", {d3_to, d3_done}); bad++; end
        tick(1);
        total++; if ({d3_to, d3_done, d3_pass, d3_hdone} !== 4'b1100) begin
            $display("FAIL timeout_fire got=%b want=1100", {d3_to, d3_done, d3_pass, d3_hdone}); bad++; end
        total++; if ({d3_cyc, d3_ins} !== 8'hff) begin
            $display("FAIL counter_saturate cyc=%0d ins=%0d want 15 15", d3_cyc, d3_ins); bad++; end
        tick(5);
        total++; if ({d3_to, d3_done, d3_pass} !== 3'b110) begin
            $display("FAIL timeout_sticky got=%b want=110", {d3_to, d3_done, d3_pass}); bad++; end
        bus3.instr_retire = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        wr0(5'd10, 32'd0);
        wr0(5'd17, 32'h5d);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++; if ({d0_done, d0_pass, d0_to, d0_hdone, d0_hpass, d0_cyc, d0_ins, d0_code} !== 100'd0) begin
            $display("FAIL reset_mid_drain done=%b cyc=%0d code=%0d want 0", d0_done, d0_cyc, d0_code); bad++; end
        wr0(5'd10, 32'd4);
        wr0(5'd17, 32'h5d);
        tick(4);
        total++; if (d0_done !== 1'b0) begin
            $display("FAIL rerun_early got=%b want=0", d0_done); bad++; end
        tick(1);
        total++; if ({d0_done, d0_pass, d0_code} !== {2'b10, 31'd2}) begin
            $display("FAIL rerun_done done=%b pass=%b code=%0d want 1 0 2", d0_done, d0_pass, d0_code); bad++; end
    endtask

    task automatic test_x0_ignored();
        do_reset();
        wr0(5'd0, 32'h5d);
        wr0(5'd1, 32'h5d);
        wr0(5'd10, 32'h5d);
        tick(20);
        total++; if ({d0_done, d0_hdone} !== 2'b00) begin
            $display("FAIL x0_write_trigger got=%b want=00", {d0_done, d0_hdone}); bad++; end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        clear_inputs();
        test_reset();
        test_pass();
        test_fail_code();
        test_ecall();
        test_two_harts();
        test_timeout();
        test_reset_mid_drain();
        test_x0_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
